// File: rtl/icache_fill_ctrl_pkg.sv
// Package for the instruction-cache fill controller.
// Holds the cache geometry, the fill FSM state encoding and the helpers that
// split a byte PC into its tag, set index and word-in-block fields.
package icache_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int NUM_SETS      = 64;
    localparam int WORDS_PER_BLK = 8;
    localparam int OFFSET_W      = 4;
    localparam int IDX_W         = $clog2(NUM_SETS);
    localparam int WORD_W        = $clog2(WORDS_PER_BLK);
    localparam int TAG_W         = ADDR_W - IDX_W - OFFSET_W;
    localparam int BLK_W         = ADDR_W - OFFSET_W;

    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        WAIT = 2'd2
    } fill_state_e;

    function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: IDX_W];
    endfunction

    // Bit 0 is the byte-within-word select and never reaches the cache.
    function automatic logic [WORD_W-1:0] word_of(input logic [ADDR_W-1:0] addr);
        return addr[1 +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_fill_ctrl_if.sv
// Bus interface of the instruction-cache fill controller.
// Bundles the fetch-stage request/response and the main-memory read port.
//   master : the environment (fetch stage + main memory) driving requests and read data
//   slave  : the cache controller answering fetches and issuing memory reads
interface icache_fill_ctrl_if;
    import icache_pkg::*;

    logic              fetch_en;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] instr;
    logic              instr_valid;
    logic              stall;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_data_valid;

    modport master (
        output fetch_en, fetch_addr, mem_data, mem_data_valid,
        input  instr, instr_valid, stall, mem_en, mem_addr
    );

    modport slave (
        input  fetch_en, fetch_addr, mem_data, mem_data_valid,
        output instr, instr_valid, stall, mem_en, mem_addr
    );

endinterface

// File: rtl/icache_fill_ctrl_data_array.sv
// Instruction data storage: NUM_SETS blocks of WORDS_PER_BLK 16-bit words.
// Ports:
//   clk                        write clock
//   wen, wr_set, wr_word, wr_data   synchronous write of one word
//   rd_set, rd_word            combinational read address
//   rd_data                    read data
// Contents are deliberately not reset; the valid bits in the controller decide
// whether a block may be used.
module icache_data_array
    import icache_pkg::*;
(
    input  logic              clk,
    input  logic              wen,
    input  logic [IDX_W-1:0]  wr_set,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_set,
    input  logic [WORD_W-1:0] rd_word,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [NUM_SETS*WORDS_PER_BLK];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[{wr_set, wr_word}] <= wr_data;
        end
    end

    assign rd_data = mem_q[{rd_set, rd_word}];

endmodule

// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a miss/fill FSM.
// Answers fetches combinationally on a hit; on a miss it stalls fetch, issues
// eight back-to-back word reads for the whole block, collects the in-order
// responses and only then marks the block valid.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        slave side of icache_fill_ctrl_if (fetch request/response and
//              main-memory read port)
module icache_fill_ctrl
    import icache_pkg::*;
(
    input logic               clk,
    input logic               rst,
    icache_fill_ctrl_if.slave bus
);

    fill_state_e         state_q, state_d;
    logic [BLK_W-1:0]    blk_q, blk_d;
    logic [WORD_W-1:0]   req_q, req_d;
    logic [WORD_W-1:0]   rsp_q, rsp_d;
    logic [NUM_SETS-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tag_q [NUM_SETS];

    logic [ADDR_W-1:0]   fill_addr;
    logic [IDX_W-1:0]    fill_idx;
    logic [IDX_W-1:0]    look_idx;
    logic                hit;
    logic [DATA_W-1:0]   rd_data;
    logic                arr_wen;
    logic                tag_wen;

    logic [DATA_W-1:0]   instr_o;
    logic                instr_valid_o;
    logic                stall_o;
    logic                mem_en_o;
    logic [ADDR_W-1:0]   mem_addr_o;

    // The block being filled is addressed only by the latched block number,
    // so the fetch PC is free to wander while the fill is in flight.
    assign fill_addr = {blk_q, {OFFSET_W{1'b0}}};
    assign fill_idx  = idx_of(fill_addr);
    assign look_idx  = idx_of(bus.fetch_addr);
    assign hit       = bus.fetch_en & valid_q[look_idx]
                     & (tag_q[look_idx] == tag_of(bus.fetch_addr));

    icache_data_array u_data (
        .clk     (clk),
        .wen     (arr_wen),
        .wr_set  (fill_idx),
        .wr_word (rsp_q),
        .wr_data (bus.mem_data),
        .rd_set  (look_idx),
        .rd_word (word_of(bus.fetch_addr)),
        .rd_data (rd_data)
    );

    // Next-state and output logic. Requests and responses are tracked by
    // separate counters because responses may already arrive while requests
    // are still being issued.
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        req_d         = req_q;
        rsp_d         = rsp_q;
        valid_d       = valid_q;
        arr_wen       = 1'b0;
        tag_wen       = 1'b0;
        instr_o       = '0;
        instr_valid_o = 1'b0;
        stall_o       = 1'b0;
        mem_en_o      = 1'b0;
        mem_addr_o    = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.fetch_en) begin
                    if (hit) begin
                        instr_valid_o = 1'b1;
                        instr_o       = rd_data;
                    end else begin
                        stall_o = 1'b1;
                        blk_d   = bus.fetch_addr[ADDR_W-1:OFFSET_W];
                        req_d   = '0;
                        rsp_d   = '0;
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                stall_o    = 1'b1;
                mem_en_o   = 1'b1;
                // The word counter sits below the block number, so the
                // address can never carry out of the block.
                mem_addr_o = {blk_q, req_q, 1'b0};
                req_d      = req_q + 1'b1;
                if (req_q == LAST_WORD) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Responses are only meaningful during a fill; anything seen in IDLE
        // is left over from an aborted fill.
        if ((state_q != IDLE) && bus.mem_data_valid) begin
            arr_wen = 1'b1;
            rsp_d   = rsp_q + 1'b1;
            if (rsp_q == LAST_WORD) begin
                tag_wen           = 1'b1;
                valid_d[fill_idx] = 1'b1;
                state_d           = IDLE;
            end
        end

        // Reset wins over everything: no array or tag update and quiet outputs.
        if (rst) begin
            arr_wen       = 1'b0;
            tag_wen       = 1'b0;
            instr_o       = '0;
            instr_valid_o = 1'b0;
            stall_o       = 1'b0;
            mem_en_o      = 1'b0;
            mem_addr_o    = '0;
        end
    end

    // Control state and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            blk_q   <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            blk_q   <= blk_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            valid_q <= valid_d;
        end
    end

    // Tag array: written only when the last word of a block lands.
    always_ff @(posedge clk) begin
        if (tag_wen) begin
            tag_q[fill_idx] <= tag_of(fill_addr);
        end
    end

    assign bus.instr       = instr_o;
    assign bus.instr_valid = instr_valid_o;
    assign bus.stall       = stall_o;
    assign bus.mem_en      = mem_en_o;
    assign bus.mem_addr    = mem_addr_o;

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Testbench for icache_fill_ctrl.
// Main memory is a fixed-latency (4 cycle) pipelined model whose word at byte
// address A holds A ^ 16'hBEEF.
module tb_icache_fill_ctrl;
    import icache_pkg::*;

    localparam int MEM_LAT = 4;

    typedef struct {
        logic        en;
        logic [15:0] addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic        e_stall;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [6];

    icache_fill_ctrl_if bus ();

    icache_fill_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Memory model: each request re-emerges MEM_LAT cycles later, in order.
    bit          pipe_v [MEM_LAT];
    logic [15:0] pipe_a [MEM_LAT];

    always @(posedge clk) begin
        pipe_v[0] <= bus.mem_en;
        pipe_a[0] <= bus.mem_addr;
        for (int i = 1; i < MEM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
        end
    end

    assign bus.mem_data_valid = pipe_v[MEM_LAT-1];
    assign bus.mem_data       = pipe_v[MEM_LAT-1] ? (pipe_a[MEM_LAT-1] ^ 16'hBEEF) : 16'h0000;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic en, input logic [15:0] addr, input logic r);
        rst            = r;
        bus.fetch_en   = en;
        bus.fetch_addr = addr;
        #1;
    endtask

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic check_output(input string name, input logic e_valid, input logic [15:0] e_instr,
                                input logic e_stall, input logic e_mem_en,
                                input logic chk_addr, input logic [15:0] e_addr);
        cmp($sformatf("%s.instr_valid", name), 16'(bus.instr_valid), 16'(e_valid));
        cmp($sformatf("%s.instr", name), bus.instr, e_instr);
        cmp($sformatf("%s.stall", name), 16'(bus.stall), 16'(e_stall));
        cmp($sformatf("%s.mem_en", name), 16'(bus.mem_en), 16'(e_mem_en));
        if (chk_addr) begin
            cmp($sformatf("%s.mem_addr", name), bus.mem_addr, e_addr);
        end
    endtask

    // Full miss sequence with exact timing: detect, eight issue cycles, four
    // cycles waiting for the tail of the responses, then the hit. From the
    // second issue cycle to the last wait cycle the PC is moved to alt_addr.
    task automatic run_fill(input string name, input logic [15:0] addr, input logic [15:0] alt_addr);
        logic [15:0] base;
        logic [15:0] want;
        base = {addr[15:4], 4'h0};
        want = {addr[15:1], 1'b0} ^ 16'hBEEF;
        next_cycle();
        apply_stimulus(1'b1, addr, 1'b0);
        check_output($sformatf("%s.detect", name), 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            apply_stimulus(1'b1, (c >= 2) ? alt_addr : addr, 1'b0);
            check_output($sformatf("%s.issue%0d", name, c), 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1,
                         base + 16'(2 * (c - 1)));
        end
        for (int c = 9; c <= 12; c++) begin
            next_cycle();
            apply_stimulus(1'b1, (c == 12) ? addr : alt_addr, 1'b0);
            check_output($sformatf("%s.wait%0d", name, c), 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        end
        next_cycle();
        apply_stimulus(1'b1, addr, 1'b0);
        check_output($sformatf("%s.hit", name), 1'b1, want, 1'b0, 1'b0, 1'b0, 16'h0000);
        next_cycle();
        apply_stimulus(1'b0, addr, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.fetch_en   = 1'b0;
        bus.fetch_addr = 16'h0000;

        vecs[0] = '{1'b1, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b1, 16'h000A, 1'b1, 16'hBEE5, 1'b0};
        vecs[2] = '{1'b1, 16'h0003, 1'b1, 16'hBEED, 1'b0};
        vecs[3] = '{1'b1, 16'h0002, 1'b1, 16'hBEED, 1'b0};
        vecs[4] = '{1'b1, 16'h000E, 1'b1, 16'hBEE1, 1'b0};
        vecs[5] = '{1'b0, 16'h000A, 1'b0, 16'h0000, 1'b0};

        // Reset held over two edges, outputs quiet.
        next_cycle();
        apply_stimulus(1'b0, 16'h0000, 1'b1);
        check_output("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);
        next_cycle();
        apply_stimulus(1'b0, 16'h0000, 1'b0);
        check_output("post_reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);

        // Cold miss on block 0x0000.
        run_fill("cold", 16'h0000, 16'h0000);

        // Hits inside the freshly filled block.
        foreach (vecs[i]) begin
            next_cycle();
            apply_stimulus(vecs[i].en, vecs[i].addr, 1'b0);
            check_output($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                         vecs[i].e_stall, 1'b0, 1'b0, 16'h0000);
        end

        // Conflict in set 0: 0x0400 evicts 0x0000, which then misses again.
        run_fill("conflict", 16'h0400, 16'h0400);
        next_cycle();
        apply_stimulus(1'b1, 16'h040C, 1'b0);
        check_output("conflict_hit", 1'b1, 16'hBAE3, 1'b0, 1'b0, 1'b0, 16'h0000);
        run_fill("refill0", 16'h0000, 16'h0000);

        // PC moves to 0x1230 mid-fill; only block 0x0020 is brought in.
        run_fill("addr_change", 16'h0020, 16'h1230);
        next_cycle();
        apply_stimulus(1'b1, 16'h002A, 1'b0);
        check_output("addr_change_hit", 1'b1, 16'hBEC5, 1'b0, 1'b0, 1'b0, 16'h0000);
        run_fill("other_blk", 16'h1230, 16'h1230);

        // Reset during the third response of a fill on 0x0040.
        next_cycle();
        apply_stimulus(1'b1, 16'h0040, 1'b0);
        check_output("rstfill.detect", 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            apply_stimulus(1'b1, 16'h0040, 1'b0);
        end
        next_cycle();
        apply_stimulus(1'b0, 16'h0040, 1'b1);
        for (int c = 8; c <= 12; c++) begin
            next_cycle();
            apply_stimulus(1'b0, 16'h0040, 1'b0);
            check_output($sformatf("rstfill.quiet%0d", c), 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000);
        end
        run_fill("after_rst0", 16'h0000, 16'h0000);
        run_fill("after_rst40", 16'h0040, 16'h0040);

        // Odd PC and the top block of the address space.
        next_cycle();
        apply_stimulus(1'b1, 16'h0003, 1'b0);
        check_output("odd_addr", 1'b1, 16'hBEED, 1'b0, 1'b0, 1'b0, 16'h0000);
        run_fill("top_blk", 16'hFFF6, 16'hFFF6);
        next_cycle();
        apply_stimulus(1'b1, 16'hFFFE, 1'b0);
        check_output("top_hit", 1'b1, 16'h4111, 1'b0, 1'b0, 1'b0, 16'h0000);

        next_cycle();
        apply_stimulus(1'b0, 16'h0000, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
